// File: rtl/tpu_pkg.sv
// Shared types and helpers for the weight-stationary matrix engine: FSM states,
// default widths, a constant clog2 and the sign/zero-extending multiply.
package tpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_OUTPUT
  } state_t;

  localparam int TPU_DATA_W = 8;
  localparam int TPU_ACC_W  = 32;

  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Operands arrive right-aligned in 64 bits; the low dw bits are the payload.
  // The caller truncates the product to its accumulator width, so wrap is modular.
  function automatic logic [63:0] ext_mul(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned dw, input logic sgn);
    logic [63:0] mask, ax, bx, sa, sb;
    mask = (dw >= 64) ? '1 : ((64'd1 << dw) - 64'd1);
    ax   = a & mask;
    bx   = b & mask;
    sa   = a >> (dw - 1);
    sb   = b >> (dw - 1);
    if (sgn && (dw > 0) && (dw < 64)) begin
      if (sa[0]) ax = ax | ~mask;
      if (sb[0]) bx = bx | ~mask;
    end
    return ax * bx;
  endfunction

endpackage

// File: rtl/tpu_ws_engine_if.sv
// Streaming data ports of the matrix engine: weight rows in, activation rows in,
// result rows out, each with a valid/ready handshake.
interface tpu_ws_engine_if #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
);
  logic                     w_valid;
  logic                     w_ready;
  logic [COLS*DATA_W-1:0]   w_data;
  logic                     a_valid;
  logic                     a_ready;
  logic [ROWS*DATA_W-1:0]   a_data;
  logic                     r_valid;
  logic                     r_ready;
  logic [COLS*ACC_W-1:0]    r_data;
  logic                     r_last;

  modport master (
    output w_valid, w_data, a_valid, a_data, r_ready,
    input  w_ready, a_ready, r_valid, r_data, r_last
  );

  modport slave (
    input  w_valid, w_data, a_valid, a_data, r_ready,
    output w_ready, a_ready, r_valid, r_data, r_last
  );
endinterface

// File: rtl/tpu_ws_pe.sv
// One processing element: holds a stationary weight, forwards the activation and its
// row tag to the right and adds its product to the partial sum passing downward.
module tpu_ws_pe
  import tpu_pkg::*;
#(
  parameter int DATA_W = TPU_DATA_W,
  parameter int ACC_W  = TPU_ACC_W,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode_signed,
  input  logic              w_load,
  input  logic [DATA_W-1:0] w_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic              v_in,
  input  logic [IDX_W-1:0]  idx_in,
  input  logic [ACC_W-1:0]  psum_in,
  output logic [DATA_W-1:0] a_out,
  output logic              v_out,
  output logic [IDX_W-1:0]  idx_out,
  output logic [ACC_W-1:0]  psum_out
);
  logic [DATA_W-1:0] w_q, w_d, a_q, a_d;
  logic              v_q, v_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ACC_W-1:0]  psum_q, psum_d;

  always_comb begin
    w_d    = w_load ? w_in : w_q;
    a_d    = a_in;
    v_d    = v_in;
    idx_d  = idx_in;
    psum_d = psum_in + ACC_W'(ext_mul(64'(a_in), 64'(w_q), DATA_W, mode_signed));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q    <= '0;
      a_q    <= '0;
      v_q    <= 1'b0;
      idx_q  <= '0;
      psum_q <= '0;
    end else begin
      w_q    <= w_d;
      a_q    <= a_d;
      v_q    <= v_d;
      idx_q  <= idx_d;
      psum_q <= psum_d;
    end
  end

  assign a_out    = a_q;
  assign v_out    = v_q;
  assign idx_out  = idx_q;
  assign psum_out = psum_q;
endmodule

// File: rtl/tpu_ws_engine.sv
// Weight-stationary matrix engine: loads ROWS weight rows, streams M activation rows
// through a skewed systolic array into a persistent result buffer, then drains it.
module tpu_ws_engine
  import tpu_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = TPU_DATA_W,
  parameter int ACC_W  = TPU_ACC_W,
  parameter int MAX_M  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [clog2(MAX_M+1)-1:0] cfg_m,
  input  logic                      cfg_signed,
  input  logic                      cfg_acc,
  tpu_ws_engine_if.slave            bus,
  output logic                      busy,
  output logic                      done
);
  localparam int M_W    = clog2(MAX_M + 1);
  localparam int IDX_W  = (MAX_M > 1) ? clog2(MAX_M) : 1;
  localparam int CNT_W  = clog2(MAX_M + ROWS + COLS + 1);
  localparam int SLOT_W = 1 + IDX_W + DATA_W;

  if (ACC_W < 2 * DATA_W + clog2(ROWS)) begin : g_acc_w_check
    $error("tpu_ws_engine: ACC_W too narrow for the reduction depth");
  end

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [M_W-1:0]    m_q, m_d;
  logic              sgn_q, sgn_d, acc_q, acc_d, done_q, done_d;
  logic              w_fire, a_fire, r_fire, r_valid, last_row;

  assign bus.w_ready = (state_q == S_LOAD_W);
  assign bus.a_ready = (state_q == S_STREAM);
  assign r_valid     = (state_q == S_OUTPUT);
  assign bus.r_valid = r_valid;
  assign w_fire      = bus.w_valid && bus.w_ready;
  assign a_fire      = bus.a_valid && bus.a_ready;
  assign r_fire      = r_valid && bus.r_ready;
  assign last_row    = (cnt_q == CNT_W'(m_q) - CNT_W'(1));
  assign bus.r_last  = r_valid && last_row;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    sgn_d   = sgn_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        if (cfg_m == '0) begin
          done_d = 1'b1;
        end else begin
          m_d     = (cfg_m > M_W'(MAX_M)) ? M_W'(MAX_M) : cfg_m;
          sgn_d   = cfg_signed;
          acc_d   = cfg_acc;
          cnt_d   = '0;
          state_d = S_LOAD_W;
        end
      end
      S_LOAD_W: if (w_fire) begin
        if (cnt_q == CNT_W'(ROWS - 1)) begin
          cnt_d   = '0;
          state_d = S_STREAM;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STREAM: if (a_fire) begin
        if (last_row) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // The last column of the last row lands in the buffer on the final drain cycle.
      S_DRAIN: begin
        if (cnt_q == CNT_W'(ROWS + COLS - 2)) begin
          cnt_d   = '0;
          state_d = S_OUTPUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_OUTPUT: if (r_fire) begin
        if (last_row) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      sgn_q   <= 1'b0;
      acc_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      sgn_q   <= sgn_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
    end
  end

  // Array fabric: activations and tags travel right, partial sums travel down.
  logic [DATA_W-1:0] a_h [ROWS][COLS+1];
  logic              v_h [ROWS][COLS+1];
  logic [IDX_W-1:0]  i_h [ROWS][COLS+1];
  logic [ACC_W-1:0]  p_v [ROWS+1][COLS];
  logic [SLOT_W-1:0] inj_slot [ROWS];

  always_comb begin
    for (int k = 0; k < ROWS; k++) begin
      inj_slot[k] = {a_fire, cnt_q[IDX_W-1:0],
                     a_fire ? bus.a_data[k*DATA_W +: DATA_W] : {DATA_W{1'b0}}};
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    logic [SLOT_W-1:0] row_slot;

    if (gi == 0) begin : g_noskew
      assign row_slot = inj_slot[0];
    end else begin : g_skew
      logic [SLOT_W-1:0] sk_q [gi];
      logic [SLOT_W-1:0] sk_d [gi];

      always_comb begin
        sk_d[0] = inj_slot[gi];
        for (int d = 1; d < gi; d++) sk_d[d] = sk_q[d-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int d = 0; d < gi; d++) sk_q[d] <= '0;
        end else begin
          sk_q <= sk_d;
        end
      end

      assign row_slot = sk_q[gi-1];
    end

    assign {v_h[gi][0], i_h[gi][0], a_h[gi][0]} = row_slot;

    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      if (gi == 0) begin : g_top
        assign p_v[0][gj] = '0;
      end

      tpu_ws_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .IDX_W  (IDX_W)
      ) u_pe (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode_signed (sgn_q),
        .w_load      (w_fire && (cnt_q == CNT_W'(gi))),
        .w_in        (bus.w_data[gj*DATA_W +: DATA_W]),
        .a_in        (a_h[gi][gj]),
        .v_in        (v_h[gi][gj]),
        .idx_in      (i_h[gi][gj]),
        .psum_in     (p_v[gi][gj]),
        .a_out       (a_h[gi][gj+1]),
        .v_out       (v_h[gi][gj+1]),
        .idx_out     (i_h[gi][gj+1]),
        .psum_out    (p_v[gi+1][gj])
      );
    end
  end

  logic unused_ok;
  always_comb begin
    unused_ok = 1'b0;
    for (int k = 0; k < ROWS; k++) begin
      unused_ok = unused_ok ^ (^a_h[k][COLS]) ^ v_h[k][COLS] ^ (^i_h[k][COLS]);
    end
  end

  // Each column writes its own element when its tag exits, which undoes the output skew.
  logic [ACC_W-1:0] buf_q [MAX_M][COLS];
  logic [ACC_W-1:0] buf_d [MAX_M][COLS];

  always_comb begin
    buf_d = buf_q;
    for (int j = 0; j < COLS; j++) begin
      if (v_h[ROWS-1][j+1]) begin
        buf_d[i_h[ROWS-1][j+1]][j] = (acc_q ? buf_q[i_h[ROWS-1][j+1]][j] : {ACC_W{1'b0}})
                                     + p_v[ROWS][j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_M; i++) begin
        for (int j = 0; j < COLS; j++) buf_q[i][j] <= '0;
      end
    end else begin
      buf_q <= buf_d;
    end
  end

  always_comb begin
    bus.r_data = '0;
    if (r_valid) begin
      for (int j = 0; j < COLS; j++) begin
        bus.r_data[j*ACC_W +: ACC_W] = buf_q[cnt_q[IDX_W-1:0]][j];
      end
    end
  end
endmodule

// File: tb/tb_tpu_ws_engine.sv
// Directed bench for tpu_ws_engine: identity, extreme-operand, accumulate, bubble/stall,
// zero/oversized M and mid-job reset jobs against a small reference model.
module tb_tpu_ws_engine;
  localparam int ROWS = 4, COLS = 4, DATA_W = 8, ACC_W = 32, MAX_M = 16, M_W = 5;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cfg_signed = 1'b0, cfg_acc = 1'b0;
  logic [M_W-1:0] cfg_m = '0;
  logic busy, done;

  tpu_ws_engine_if #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  tpu_ws_engine #(
    .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W), .MAX_M(MAX_M)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_m(cfg_m), .cfg_signed(cfg_signed),
    .cfg_acc(cfg_acc), .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0]  am  [MAX_M][ROWS];
  logic [7:0]  bm  [ROWS][COLS];
  logic [31:0] mdl [MAX_M][COLS];
  logic [31:0] got [MAX_M][COLS];
  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dot(input int i, input int j, input bit sgn);
    int s, x, y;
    s = 0;
    for (int k = 0; k < ROWS; k++) begin
      x = sgn ? int'($signed(am[i][k])) : int'(am[i][k]);
      y = sgn ? int'($signed(bm[k][j])) : int'(bm[k][j]);
      s = s + x * y;
    end
    return 32'(s);
  endfunction

  function automatic logic [COLS*DATA_W-1:0] pack_w(input int k);
    logic [COLS*DATA_W-1:0] v;
    for (int j = 0; j < COLS; j++) v[j*DATA_W +: DATA_W] = bm[k][j];
    return v;
  endfunction

  function automatic logic [ROWS*DATA_W-1:0] pack_a(input int i);
    logic [ROWS*DATA_W-1:0] v;
    for (int k = 0; k < ROWS; k++) v[k*DATA_W +: DATA_W] = am[i][k];
    return v;
  endfunction

  task automatic set_identity();
    for (int i = 0; i < MAX_M; i++)
      for (int k = 0; k < ROWS; k++) am[i][k] = (i == k) ? 8'd1 : 8'd0;
    for (int k = 0; k < ROWS; k++)
      for (int j = 0; j < COLS; j++) bm[k][j] = 8'(k + j + 1);
  endtask

  task automatic check_identity(input string name, input int scale);
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++)
        chk($sformatf("%s_hand_r%0d_c%0d", name, i, j), got[i][j], 64'(scale * (i + j + 1)));
  endtask

  task automatic run_job(input int m_cfg, input bit sgn, input bit acc,
                         input int bub, input int stl, input string name);
    int m, kw, ia, nr, cyc, first_r;
    bit prev_stall, w_drop_seen;
    logic [COLS*ACC_W-1:0] prev_data;
    logic prev_last;
    m = (m_cfg > MAX_M) ? MAX_M : m_cfg;
    for (int i = 0; i < m; i++)
      for (int j = 0; j < COLS; j++) mdl[i][j] = (acc ? mdl[i][j] : 32'd0) + dot(i, j, sgn);
    cfg_m = M_W'(m_cfg); cfg_signed = sgn; cfg_acc = acc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, "_busy"}, busy, 1);
    kw = 0; ia = 0; nr = 0; cyc = 0; first_r = -1; prev_stall = 0; w_drop_seen = 0;
    prev_data = '0; prev_last = 1'b0;
    while (nr < m && cyc < 3000) begin
      if (kw == ROWS && !w_drop_seen) begin
        chk({name, "_w_ready_drop"}, bus.w_ready, 0);
        w_drop_seen = 1;
      end
      bus.w_valid = (kw < ROWS);
      bus.w_data  = pack_w((kw < ROWS) ? kw : 0);
      bus.a_valid = (ia < m) && ($urandom_range(0, 99) >= bub);
      bus.a_data  = pack_a((ia < m) ? ia : 0);
      bus.r_ready = ($urandom_range(0, 99) >= stl);
      if (prev_stall)
        chk({name, "_hold"}, bus.r_valid && (bus.r_data == prev_data) && (bus.r_last == prev_last), 1);
      if (bus.r_valid) begin
        if (first_r < 0) first_r = cyc;
        if (bus.r_ready) begin
          for (int j = 0; j < COLS; j++) begin
            got[nr][j] = bus.r_data[j*ACC_W +: ACC_W];
            chk($sformatf("%s_r%0d_c%0d", name, nr, j), got[nr][j], mdl[nr][j]);
          end
          chk($sformatf("%s_last_r%0d", name, nr), bus.r_last, (nr == m - 1) ? 1 : 0);
          $display("%s row %0d data %h last %0b", name, nr, bus.r_data, bus.r_last);
          nr++;
        end
        prev_stall = !bus.r_ready; prev_data = bus.r_data; prev_last = bus.r_last;
      end else begin
        prev_stall = 0;
      end
      if (bus.w_valid && bus.w_ready) kw++;
      if (bus.a_valid && bus.a_ready) ia++;
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, "_rows"}, nr, m);
    bus.w_valid = 1'b0; bus.a_valid = 1'b0; bus.r_ready = 1'b0;
    chk({name, "_done"}, done, 1);
    chk({name, "_idle_busy"}, busy, 0);
    chk({name, "_idle_rvalid"}, bus.r_valid, 0);
    // cyc 0 is the cycle after start
    if (bub == 0 && stl == 0)
      chk({name, "_latency"}, first_r, (1 + ROWS + m + ROWS + COLS - 1) - 1);
    @(posedge clk); #1;
    chk({name, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int kw, ia, cyc;
    bit seen;
    bus.w_valid = 1'b0; bus.w_data = '0; bus.a_valid = 1'b0; bus.a_data = '0; bus.r_ready = 1'b0;
    for (int i = 0; i < MAX_M; i++)
      for (int j = 0; j < COLS; j++) mdl[i][j] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_w_ready", bus.w_ready, 0);
    chk("rst_a_ready", bus.a_ready, 0);
    chk("rst_r_valid", bus.r_valid, 0);
    chk("rst_r_last", bus.r_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_r_data_lo", bus.r_data[63:0], 0);
    chk("rst_r_data_hi", bus.r_data[127:64], 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    set_identity();
    run_job(4, 1, 0, 0, 0, "id0");
    check_identity("id0", 1);
    run_job(4, 1, 1, 0, 0, "id_acc");
    check_identity("id_acc", 2);
    run_job(4, 1, 0, 0, 0, "id_again");
    check_identity("id_again", 1);

    for (int k = 0; k < ROWS; k++) begin
      am[0][k] = 8'hFF;
      for (int j = 0; j < COLS; j++) bm[k][j] = 8'h7F;
    end
    run_job(1, 1, 0, 0, 0, "ff_s");
    for (int j = 0; j < COLS; j++) chk($sformatf("ff_s_hand_c%0d", j), got[0][j], 32'hFFFF_FE04);
    run_job(1, 0, 0, 0, 0, "ff_u");
    for (int j = 0; j < COLS; j++) chk($sformatf("ff_u_hand_c%0d", j), got[0][j], 32'd129540);

    for (int i = 0; i < MAX_M; i++)
      for (int k = 0; k < ROWS; k++) am[i][k] = 8'($urandom);
    for (int k = 0; k < ROWS; k++)
      for (int j = 0; j < COLS; j++) bm[k][j] = 8'($urandom);
    run_job(16, 1, 1, 30, 40, "m16_acc");

    cfg_m = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("m0_done", done, 1);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      seen = seen | bus.w_ready | bus.a_ready | bus.r_valid | busy;
      @(posedge clk); #1;
    end
    chk("m0_quiet", seen, 0);
    chk("m0_done_clear", done, 0);

    for (int i = 0; i < MAX_M; i++)
      for (int k = 0; k < ROWS; k++) am[i][k] = 8'($urandom);
    run_job(20, 0, 0, 20, 30, "m20_sat");

    set_identity();
    cfg_m = 5'd4; cfg_signed = 1'b1; cfg_acc = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    kw = 0; ia = 0; cyc = 0;
    while (ia < 2 && cyc < 50) begin
      bus.w_valid = (kw < ROWS); bus.w_data = pack_w((kw < ROWS) ? kw : 0);
      bus.a_valid = 1'b1; bus.a_data = pack_a(ia);
      if (bus.w_valid && bus.w_ready) kw++;
      if (bus.a_valid && bus.a_ready) ia++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("mid_reached_stream", ia, 2);
    rst_n = 1'b0;
    #1;
    bus.w_valid = 1'b0; bus.a_valid = 1'b0;
    chk("mid_w_ready", bus.w_ready, 0);
    chk("mid_a_ready", bus.a_ready, 0);
    chk("mid_r_valid", bus.r_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_r_data_lo", bus.r_data[63:0], 0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_no_done", done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < MAX_M; i++)
      for (int j = 0; j < COLS; j++) mdl[i][j] = 32'd0;
    run_job(4, 1, 1, 0, 0, "post_rst");
    check_identity("post_rst", 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/tpu_ws_engine.md
Name: tpu_ws_engine

Overview:
Parametrised second-generation INT8 weight-stationary matrix engine. Computes C[M x COLS] = A[M x ROWS] * B[ROWS x COLS], optionally accumulating onto the previous C, for M up to MAX_M.
- Differences from the current TPU top: valid/ready streaming on all data ports, runtime signed/unsigned mode, K-tiling accumulate mode, variable M, row-serial back-pressured result drain.
- Sits between the DMA/feeder and the result writeback.

Parameters:
ROWS, 4, reduction depth K; PE rows; one weight row per PE row
COLS, 4, output columns; PE columns
DATA_W, 8, operand width
ACC_W, 32, accumulator width; must be >= 2*DATA_W + clog2(ROWS) (elaboration-time check)
MAX_M, 16, maximum activation rows per job; result buffer depth

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  job start pulse; sampled only in IDLE
cfg_m  in  clog2(MAX_M+1)  activation row count; sampled with start
cfg_signed  in  1  1: operands two's complement; 0: unsigned; sampled with start
cfg_acc  in  1  1: add results onto stored C; 0: overwrite; sampled with start
w_valid  in  1  weight row valid
w_ready  out  1  weight row accept
w_data  in  COLS*DATA_W  weight row k; element j at [j*DATA_W +: DATA_W]
a_valid  in  1  activation row valid
a_ready  out  1  activation row accept
a_data  in  ROWS*DATA_W  activation row i; element k at [k*DATA_W +: DATA_W]
r_valid  out  1  result row valid
r_ready  in  1  result row accept
r_data  out  COLS*ACC_W  result row i; element j at [j*ACC_W +: ACC_W]
r_last  out  1  marks final result row of the job
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at job end

Behaviour:
- Reset (async assert, sync deassert): state IDLE; w_ready, a_ready, r_valid, r_last, busy, done = 0; r_data = 0; PE weights, pipeline, result buffer and valid tags cleared.
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, OUTPUT.
- IDLE:
  - start with cfg_m = 0: stay IDLE, done = 1 next cycle, no handshakes, buffer untouched.
  - start with cfg_m > MAX_M: saturate to MAX_M.
  - Otherwise latch cfg, go to LOAD_W.
  - start outside IDLE is ignored.
- LOAD_W:
  - w_ready = 1. Each w handshake loads the next PE row (k = 0..ROWS-1).
  - After ROWS handshakes go to STREAM; w_ready drops the same cycle as the last handshake.
- STREAM:
  - a_ready = 1. Each handshake injects row i (0..M-1) with per-row skew: element k delayed k cycles.
  - Each injected row carries a valid tag plus row index through the array. Bubbles (a_valid low) propagate as invalid slots.
  - Results are independent of the bubble pattern.
  - After the M-th handshake go to DRAIN; a_ready drops.
- DRAIN:
  - Fixed ROWS+COLS-1 cycles after the last accept; all tagged rows land in the buffer.
  - Write rule: buffer[i][j] = (cfg_acc ? buffer[i][j] : 0) + dot(A row i, B col j).
  - Then go to OUTPUT.
- OUTPUT:
  - r_valid = 1, r_data = buffer row n for n = 0..M-1; r_last = 1 on n = M-1.
  - r_data and r_last are held stable while r_valid && !r_ready.
  - On the final handshake: r_valid = 0, go to IDLE, done = 1 the next cycle; busy falls with the IDLE entry.
- Arithmetic:
  - Operands extended to ACC_W per cfg_signed (sign or zero extension).
  - Products and sums wrap modulo 2^ACC_W; no saturation.
- Buffer persistence:
  - Buffer is retained between jobs and cleared only by reset.
  - cfg_acc with a larger M than the prior job adds onto the retained or zero contents of the extra rows.
- Latency (no bubbles, r_ready = 1): start -> first r_valid = 1 + ROWS + M + ROWS+COLS-1 cycles.
- Reset mid-job: immediate abort to IDLE with full clear; no done pulse.

Decomposition:
- Package tpu_pkg:
  - FSM state enum
  - default DATA_W/ACC_W constants
  - clog2 function
  - ext_mul function: signed/unsigned extend and multiply
- One sub-module, tpu_ws_pe:
  - holds one weight
  - registers activation, valid tag and row index rightward
  - registers partial sum downward
  - mode input selects signed/unsigned
- tpu_ws_engine owns the FSM, input skew registers, output deskew, result buffer and drain.

Test Plan:
- Identity A (4x4), B[k][j] = k+j+1, cfg_signed = 1, cfg_acc = 0 -> r_data row i equals B row i (e.g. row 0 = 1,2,3,4); r_last on row 3; done 1 cycle after the last handshake.
- A all 8'hFF, B all 8'h7F, M = 1: cfg_signed = 1 -> every element -508; cfg_signed = 0 -> every element 129540.
- Repeat the identity job with cfg_acc = 1 -> every element doubled (row 0 = 2,4,6,8); a third run with cfg_acc = 0 -> back to 1,2,3,4.
- M = MAX_M = 16, random a_valid bubbles and r_ready toggling -> results match the golden model; r_data/r_last stable during stalls; exactly 16 result handshakes.
- cfg_m = 0 -> done high the cycle after start, w_ready/a_ready/r_valid never assert. cfg_m = 20 -> 16 rows output.
- rst_n pulsed low mid-STREAM -> all outputs 0 immediately, no done; a new identity job afterwards with cfg_acc = 1 returns B exactly (buffer cleared).
